// File: rtl/sincronizador_botoes.sv
// Two-flop synchronizer that brings the raw push-button vector into the clock domain.
// Both stages clear on reset so no stale press survives a reset.
module sincronizador_botoes (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  output logic [3:0] sinc
);

  logic [3:0] meta_q;
  logic [3:0] meta_d;
  logic [3:0] sinc_q;
  logic [3:0] sinc_d;

  always_comb begin
    meta_d = botoes;
    sinc_d = meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= meta_d;
      sinc_q <= sinc_d;
    end
  end

  assign sinc = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounced single-press detector for four push-buttons; emits one jogada pulse per
// accepted one-hot press, or one multiplo pulse when several buttons were held together.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic       jogada,
  output logic [3:0] jogada_codigo,
  output logic       multiplo,
  output logic [2:0] db_estado
);

  // jogada and multiplo are one-cycle Moore pulses decoded from the state register:
  // the consumer samples them on the next rising edge; there is no back-pressure.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ESPERA        = 3'd0,
    FILTRA        = 3'd1,
    PULSO         = 3'd2,
    ERRO          = 3'd3,
    ESPERA_SOLTAR = 3'd4,
    FILTRA_SOLTAR = 3'd5
  } estado_t;

  logic [3:0]       sinc;
  estado_t          estado_q;
  estado_t          estado_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       capt_q;
  logic [3:0]       capt_d;
  logic [3:0]       codigo_q;
  logic [3:0]       codigo_d;

  sincronizador_botoes u_sinc (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .sinc   (sinc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
      cnt_q    <= '0;
      capt_q   <= '0;
      codigo_q <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      capt_q   <= capt_d;
      codigo_q <= codigo_d;
    end
  end

  // The counter is either cleared on entry or the state is left at CNT_LAST, so it never wraps.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    capt_d   = capt_q;
    codigo_d = codigo_q;
    case (estado_q)
      ESPERA: begin
        if (habilita && (sinc != 4'b0000)) begin
          estado_d = FILTRA;
          capt_d   = sinc;
          cnt_d    = '0;
        end
      end
      FILTRA: begin
        if (!habilita || (sinc != capt_q)) begin
          estado_d = ESPERA;
        end else if (cnt_q == CNT_LAST) begin
          if ($onehot(capt_q)) begin
            estado_d = PULSO;
            codigo_d = capt_q;
          end else begin
            estado_d = ERRO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PULSO:   estado_d = ESPERA_SOLTAR;
      ERRO:    estado_d = ESPERA_SOLTAR;
      ESPERA_SOLTAR: begin
        if (sinc == 4'b0000) begin
          estado_d = FILTRA_SOLTAR;
          cnt_d    = '0;
        end
      end
      FILTRA_SOLTAR: begin
        if (sinc != 4'b0000) begin
          estado_d = ESPERA_SOLTAR;
        end else if (cnt_q == CNT_LAST) begin
          estado_d = ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_comb begin
    jogada        = (estado_q == PULSO);
    multiplo      = (estado_q == ERRO);
    db_estado     = estado_q;
    jogada_codigo = codigo_q;
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CYCLES=4: a per-cycle vector table
// plus hand-written sequences for bouncing, reset mid-press and short releases.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic       jogada;
  logic [3:0] jogada_codigo;
  logic       multiplo;
  logic [2:0] db_estado;

  int checks  = 0;
  int errors  = 0;
  int jog_cnt = 0;
  int mul_cnt = 0;

  detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes        (botoes),
    .habilita      (habilita),
    .jogada        (jogada),
    .jogada_codigo (jogada_codigo),
    .multiplo      (multiplo),
    .db_estado     (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       hab;
    logic [3:0] btn;
    logic [2:0] st;
    logic       jog;
    logic       mul;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic rst, input logic hab, input logic [3:0] btn,
                     input logic [2:0] st, input logic jog, input logic mul, input logic [3:0] code);
    vec_t v;
    v.rst = rst; v.hab = hab; v.btn = btn; v.st = st; v.jog = jog; v.mul = mul; v.code = code;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic hab, input logic [3:0] btn);
    @(negedge clock);
    reset    = rst;
    habilita = hab;
    botoes   = btn;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Counts edges from the next rising edge (edge 0) until jogada is seen, bounded.
  task automatic expect_jogada_after(input string name, input int exp_edges, input logic [3:0] exp_code);
    int  n;
    bit  found;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clock);
      #1;
      if (jogada) found = 1;
      else n++;
    end
    check({name, "_latency"}, n, exp_edges);
    check({name, "_code"}, int'(jogada_codigo), int'(exp_code));
  endtask

  // scoreboard monitor: pulse counts and mutual exclusion every cycle
  always @(negedge clock) begin
    if (jogada) jog_cnt++;
    if (multiplo) mul_cnt++;
    checks++;
    if (jogada && multiplo) begin
      errors++;
      $display("FAIL exclusive: jogada=1 multiplo=1 required not both high");
    end
  end

  initial begin
    int base_j;
    int base_m;
    reset = 1'b1;
    habilita = 1'b0;
    botoes = 4'b0000;

    // reset, clean press 0100 and release
    add(2, 1, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(2, 0, 1, 4'b0100, 0, 0, 0, 4'b0000);
    add(4, 0, 1, 4'b0100, 1, 0, 0, 4'b0000);
    add(1, 0, 1, 4'b0100, 2, 1, 0, 4'b0100);
    add(13, 0, 1, 4'b0100, 4, 0, 0, 4'b0100);
    add(2, 0, 1, 4'b0000, 4, 0, 0, 4'b0100);
    add(4, 0, 1, 4'b0000, 5, 0, 0, 4'b0100);
    add(2, 0, 1, 4'b0000, 0, 0, 0, 4'b0100);
    // two buttons: multiplo, code kept
    add(2, 0, 1, 4'b0011, 0, 0, 0, 4'b0100);
    add(4, 0, 1, 4'b0011, 1, 0, 0, 4'b0100);
    add(1, 0, 1, 4'b0011, 3, 0, 1, 4'b0100);
    add(3, 0, 1, 4'b0011, 4, 0, 0, 4'b0100);
    add(2, 0, 1, 4'b0000, 4, 0, 0, 4'b0100);
    add(4, 0, 1, 4'b0000, 5, 0, 0, 4'b0100);
    add(2, 0, 1, 4'b0000, 0, 0, 0, 4'b0100);
    // press 1000
    add(2, 0, 1, 4'b1000, 0, 0, 0, 4'b0100);
    add(4, 0, 1, 4'b1000, 1, 0, 0, 4'b0100);
    add(1, 0, 1, 4'b1000, 2, 1, 0, 4'b1000);
    add(3, 0, 1, 4'b1000, 4, 0, 0, 4'b1000);
    add(2, 0, 1, 4'b0000, 4, 0, 0, 4'b1000);
    add(4, 0, 1, 4'b0000, 5, 0, 0, 4'b1000);
    add(1, 0, 1, 4'b0000, 0, 0, 0, 4'b1000);
    // habilita low blocks the press; raising it while held accepts it
    add(6, 0, 0, 4'b0010, 0, 0, 0, 4'b1000);
    add(4, 0, 1, 4'b0010, 1, 0, 0, 4'b1000);
    add(1, 0, 1, 4'b0010, 2, 1, 0, 4'b0010);
    add(2, 0, 1, 4'b0010, 4, 0, 0, 4'b0010);
    // habilita dropped during release states must not abort them
    add(2, 0, 0, 4'b0000, 4, 0, 0, 4'b0010);
    add(4, 0, 0, 4'b0000, 5, 0, 0, 4'b0010);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 4'b0010);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].hab, vecs[i].btn);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_estado", i), int'(db_estado), int'(vecs[i].st));
      check($sformatf("vec%0d_jogada", i), int'(jogada), int'(vecs[i].jog));
      check($sformatf("vec%0d_multiplo", i), int'(multiplo), int'(vecs[i].mul));
      check($sformatf("vec%0d_codigo", i), int'(jogada_codigo), int'(vecs[i].code));
    end

    // bouncing 0001: 2-cycle phases, then held
    drive(0, 1, 4'b0000);
    run(2);
    base_j = jog_cnt;
    base_m = mul_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, (i % 2 == 1) ? 4'b0001 : 4'b0000);
      run(2);
    end
    check("bounce_no_jogada", jog_cnt - base_j, 0);
    drive(0, 1, 4'b0001);
    expect_jogada_after("bounce_settle", 6, 4'b0001);
    run(10);
    check("bounce_single_jogada", jog_cnt - base_j, 1);
    check("bounce_no_multiplo", mul_cnt - base_m, 0);
    drive(0, 1, 4'b0000);
    run(8);
    #1;
    check("bounce_released_estado", int'(db_estado), 0);

    // reset mid-FILTRA cancels the press
    base_j = jog_cnt;
    drive(0, 1, 4'b0100);
    run(5);
    #1;
    check("rst_mid_filtra_estado", int'(db_estado), 1);
    drive(1, 1, 4'b0100);
    #1;
    check("rst_estado", int'(db_estado), 0);
    check("rst_jogada", int'(jogada), 0);
    check("rst_multiplo", int'(multiplo), 0);
    check("rst_codigo", int'(jogada_codigo), 0);
    run(3);
    check("rst_no_pulse", jog_cnt - base_j, 0);
    drive(0, 1, 4'b0100);
    expect_jogada_after("after_rst", 6, 4'b0100);
    drive(0, 1, 4'b0000);
    run(8);

    // short release is not a release
    drive(0, 1, 4'b0001);
    expect_jogada_after("short_rel_first", 6, 4'b0001);
    run(2);
    drive(0, 1, 4'b0000);
    run(2);
    drive(0, 1, 4'b0001);
    run(1);
    #1;
    check("short_rel_filtra_soltar", int'(db_estado), 5);
    run(2);
    #1;
    check("short_rel_back_espera_soltar", int'(db_estado), 4);
    base_j = jog_cnt;
    run(20);
    #1;
    check("short_rel_ignored", jog_cnt - base_j, 0);
    check("short_rel_still_held", int'(db_estado), 4);
    drive(0, 1, 4'b0000);
    run(6);
    #1;
    check("full_rel_filtering", int'(db_estado), 5);
    run(1);
    #1;
    check("full_rel_done", int'(db_estado), 0);
    drive(0, 1, 4'b0010);
    expect_jogada_after("second_press", 6, 4'b0010);
    drive(0, 1, 4'b0000);
    run(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
